// File: rtl/prio_event_encoder.sv
// Registered priority encoder: sticky rising-edge pending bits, per-source mask, valid/ready grant port.
// Define PRIO_ROUND_ROBIN_EN for rotating priority; the default build is fixed priority (highest index wins).
module prio_event_encoder #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic                 clr_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_id,
  output logic [N-1:0]         pending,
  output logic [N-1:0]         overflow,
  output logic                 o_dbg_state
);

  localparam int IDW = $clog2(N);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  // Output handshake: out_id is transferred on a cycle where out_valid and out_ready
  // are both high; out_id is held stable while out_valid is high and out_ready is low.

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_req_q;
  logic [N-1:0]   r_pending;
  logic [N-1:0]   r_overflow;
  logic [IDW-1:0] r_out_id;

  logic [N-1:0]   w_rise;
  logic [N-1:0]   w_cand;
  logic [IDW-1:0] w_winner;
  logic           w_any;
  logic           w_hs;
  logic           w_load;
  logic [N-1:0]   w_clr;
  logic [N-1:0]   w_ovf_set;

  assign w_rise = req & ~r_req_q;
  assign w_cand = r_pending & mask;
  assign w_any  = |w_cand;
  assign w_hs   = (r_state == S_PRESENT) && out_ready;

`ifdef PRIO_ROUND_ROBIN_EN
  logic [IDW-1:0] r_last_id;
  logic           w_found;

  // Search downward from last_id-1, wrapping to N-1; last_id itself is tried last.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(r_last_id) >= k) ? (int'(r_last_id) - k) : (int'(r_last_id) + N - k);
      if (!w_found && w_cand[IDW'(idx)]) begin
        w_found  = 1'b1;
        w_winner = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_id <= '0;
    end else if (w_load) begin
      r_last_id <= w_winner;
    end
  end
`else
  always_comb begin
    w_winner = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand[i]) begin
        w_winner = IDW'(i);
      end
    end
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_state_nxt = S_PRESENT;
      S_PRESENT: if (w_hs && !w_any) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    w_load = 1'b0;
    case (r_state)
      S_IDLE:    w_load = w_any;
      S_PRESENT: w_load = w_hs && w_any;
      default:   w_load = 1'b0;
    endcase
    w_clr = w_load ? (N'(1) << w_winner) : '0;
    w_ovf_set = w_rise & r_pending & ~w_clr;
    if ((r_state == S_PRESENT) && !w_hs) begin
      w_ovf_set = w_ovf_set | (w_rise & (N'(1) << r_out_id));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_q    <= '0;
      r_pending  <= '0;
      r_overflow <= '0;
      r_out_id   <= '0;
    end else begin
      r_req_q   <= req;
      // A new rise wins over the grant clear on the same bit.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (clr_ovf) begin
        r_overflow <= w_ovf_set;
      end else begin
        r_overflow <= r_overflow | w_ovf_set;
      end
      if (w_load) begin
        r_out_id <= w_winner;
      end
    end
  end

  assign out_valid   = (r_state == S_PRESENT);
  assign out_id      = r_out_id;
  assign pending     = r_pending;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prio_event_encoder.sv
// Directed bench for prio_event_encoder (N = 8): latency, priority, backpressure, mask,
// overflow, asynchronous reset and grant ordering in either priority mode.
module tb_prio_event_encoder;

  localparam int N   = 8;
  localparam int IDW = $clog2(N);

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   mask;
  logic           clr_ovf;
  logic           out_valid;
  logic           out_ready;
  logic [IDW-1:0] out_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   overflow;
  logic           dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IDW-1:0] exp_q[$];

  prio_event_encoder #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .mask        (mask),
    .clr_ovf     (clr_ovf),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_id      (out_id),
    .pending     (pending),
    .overflow    (overflow),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req       = '0;
    out_ready = 1'b1;
    mask      = 8'hFF;
    for (int i = 0; i < 10; i++) tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    mask      = 8'hFF;
    clr_ovf   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_id", 32'(out_id), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    rst = 1'b0;
    tick();

    // Basic latency
    req = 8'h20;
    tick();
    check("basic_pend", 32'(pending), 32'h20);
    check("basic_nv", 32'(out_valid), 32'h0);
    tick();
    check("basic_valid", 32'(out_valid), 32'h1);
    check("basic_id", 32'(out_id), 32'h5);
    check("basic_pend0", 32'(pending), 32'h0);
    req = '0;
    tick();
    check("basic_idle", 32'(out_valid), 32'h0);

    // Priority with backpressure
    out_ready = 1'b0;
    req = 8'hC4;
    tick();
    check("prio_pend", 32'(pending), 32'hC4);
    tick();
    check("prio_id7", 32'(out_id), 32'h7);
    check("prio_pend2", 32'(pending), 32'h44);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'h1);
      check("stall_id", 32'(out_id), 32'h7);
    end
    out_ready = 1'b1;
    tick();
    check("b2b_id6", 32'(out_id), 32'h6);
    check("b2b_v6", 32'(out_valid), 32'h1);
    tick();
    check("b2b_id2", 32'(out_id), 32'h2);
    check("b2b_v2", 32'(out_valid), 32'h1);
    tick();
    check("b2b_end", 32'(out_valid), 32'h0);
    check("b2b_pend", 32'(pending), 32'h0);
    req = '0;
    tick();

    // Mask holds a pending source back
    mask = 8'hF7;
    req  = 8'h08;
    tick();
    req = '0;
    tick();
    tick();
    check("mask_nv", 32'(out_valid), 32'h0);
    check("mask_pend", 32'(pending), 32'h08);
    out_ready = 1'b0;
    mask = 8'hFF;
    tick();
    tick();
    check("mask_valid", 32'(out_valid), 32'h1);
    check("mask_id3", 32'(out_id), 32'h3);
    out_ready = 1'b1;
    tick();
    check("mask_done", 32'(out_valid), 32'h0);
    check("mask_pend0", 32'(pending), 32'h0);

    // Overflow on a masked pending source
    mask = 8'hEF;
    req  = 8'h10;
    tick();
    for (int i = 0; i < 2; i++) begin
      req = '0;
      tick();
      req = 8'h10;
      tick();
    end
    check("ovf_set", 32'(overflow), 32'h10);
    check("ovf_pend", 32'(pending), 32'h10);
    req = '0;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr", 32'(overflow), 32'h0);
    req = 8'h10;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'h10);
    drain();
    check("ovf_drained", 32'(overflow), 32'h0);
    check("ovf_pend0", 32'(pending), 32'h0);

    // Overflow on a rise of the source currently presented and stalled
    out_ready = 1'b0;
    req = 8'h02;
    tick();
    tick();
    check("pres_id1", 32'(out_id), 32'h1);
    req = '0;
    tick();
    req = 8'h02;
    tick();
    check("pres_ovf", 32'(overflow), 32'h02);
    check("pres_pend", 32'(pending), 32'h02);
    drain();

    // Asynchronous reset while presenting
    out_ready = 1'b0;
    mask = 8'h40;
    req  = 8'hC1;
    tick();
    tick();
    check("pre_rst_id", 32'(out_id), 32'h6);
    check("pre_rst_pend", 32'(pending), 32'h81);
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_id", 32'(out_id), 32'h0);
    check("arst_pend", 32'(pending), 32'h0);
    check("arst_ovf", 32'(overflow), 32'h0);
    mask = 8'hFF;
    tick();
    rst = 1'b0;
    tick();
    check("rel_rise_pend", 32'(pending), 32'hC1);
    tick();
    check("rel_id7", 32'(out_id), 32'h7);
    drain();

    // Grant order with two sources re-raised after every grant
`ifdef PRIO_ROUND_ROBIN_EN
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd1);
`else
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd7);
`endif
    out_ready = 1'b0;
    req = 8'h82;
    tick();
    tick();
    check("rr_valid0", 32'(out_valid), 32'h1);
    check("rr_grant0", 32'(out_id), 32'(exp_q.pop_front()));
    for (int g = 1; g < 4; g++) begin
      req = '0;
      tick();
      req = 8'h82;
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("rr_valid", 32'(out_valid), 32'h1);
      check("rr_grant", 32'(out_id), 32'(exp_q.pop_front()));
    end
    drain();
    check("end_idle", 32'(out_valid), 32'h0);
    check("end_pend", 32'(pending), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
